// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, in-order instruction fetch with FIFO, and branch/jump redirect
module pc_fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_N,
  input  logic            ex_Z,
  input  logic            ex_C,
  input  logic            ex_V,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_imm,
  output logic            redirect,
  output logic            misaligned
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] fetch_pc, target, jalr_sum;
  logic [CW-1:0]   outstanding, drop, fifo_count;
  logic [CW:0]     in_use;
  logic [AW-1:0]   wptr, rptr, tag_wptr, tag_rptr;
  logic [31:0]     fifo_data [DEPTH];
  logic [XLEN-1:0] fifo_pc [DEPTH];
  logic [XLEN-1:0] tag_pc [DEPTH];
  logic            cond, taken, accept, resp, push, pop;
  // Resolve control flow, gate issue on total buffer occupancy, and expose the FIFO head
  always_comb begin
    cond = ex_funct3 == 3'b000 ? ex_Z :
           ex_funct3 == 3'b001 ? ~ex_Z :
           ex_funct3 == 3'b100 ? ex_N ^ ex_V :
           ex_funct3 == 3'b101 ? ~(ex_N ^ ex_V) :
           ex_funct3 == 3'b110 ? ~ex_C :
           ex_funct3 == 3'b111 ? ex_C : 1'b0;
    jalr_sum = ex_rs1 + ex_imm;
    target = ex_jalr ? (jalr_sum & ~XLEN'(1)) : ex_pc + ex_imm;
    taken = rst & ex_valid & (ex_jal | ex_jalr | (ex_branch & cond));
    redirect = taken & (target[1:0] == 2'b00);
    misaligned = taken & (target[1:0] != 2'b00);
    in_use = {1'b0, outstanding} + {1'b0, fifo_count};
    imem_req = rst & ~redirect & (in_use < (CW+1)'(DEPTH));
    imem_addr = fetch_pc;
    accept = imem_req & imem_gnt;
    resp = imem_rvalid & (outstanding != '0);
    push = resp & (drop == '0) & ~redirect;
    instr_valid = fifo_count != '0;
    pop = instr_valid & instr_ready;
    instr = instr_valid ? fifo_data[rptr] : '0;
    instr_pc = instr_valid ? fifo_pc[rptr] : '0;
  end
  // Counters and pointers; a redirect turns every in-flight response into one to drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_VECTOR;
      outstanding <= '0;
      drop <= '0;
      fifo_count <= '0;
      wptr <= '0;
      rptr <= '0;
      tag_wptr <= '0;
      tag_rptr <= '0;
    end else begin
      fetch_pc <= redirect ? target : accept ? fetch_pc + XLEN'(4) : fetch_pc;
      outstanding <= outstanding + CW'(accept) - CW'(resp);
      drop <= redirect ? outstanding - CW'(resp) : drop - CW'(resp && drop != '0);
      fifo_count <= redirect ? '0 : fifo_count + CW'(push) - CW'(pop);
      wptr <= wptr + AW'(push);
      rptr <= redirect ? wptr : rptr + AW'(pop);
      tag_wptr <= tag_wptr + AW'(accept);
      tag_rptr <= tag_rptr + AW'(resp);
    end
  end
  // Storage for request PC tags and buffered instructions
  always_ff @(posedge clk) begin
    if (accept) tag_pc[tag_wptr] <= fetch_pc;
    if (push) begin
      fifo_data[wptr] <= imem_rdata;
      fifo_pc[wptr] <= tag_pc[tag_rptr];
    end
  end
endmodule
